inv_sub_bytes_seq: RTL
======================

# inv_sub_bytes_seq

Sequential AES-128 InvSubBytes stage for the decrypt datapath, placed directly downstream of the inverse row-shift stage and upstream of the round-key addition. It accepts one 128-bit state per handshake, replaces every byte with its inverse S-box value, and returns the 128-bit result over an output handshake. It processes LANES bytes per cycle, so area and throughput are traded through one parameter.

## Interface
- LANES, 4, inverse S-box instances, i.e. bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a state on data_in.
- in_ready  out  1  block can accept a state this cycle.
- data_in  in  128  state; byte 0 is [127:120], byte 15 is [7:0].
- out_valid  out  1  data_out holds a complete result.
- out_ready  in  1  downstream accepts data_out this cycle.
- data_out  out  128  substituted state, same byte order as data_in.

## Operation
- N = 16/LANES processing cycles per state.
- FSM states:
  - IDLE: in_ready=1. On in_valid, register data_in into the working buffer, clear the chunk counter, and go to BUSY.
  - BUSY: each cycle, substitute chunk k (bytes k·LANES to k·LANES+LANES-1, MSB chunk first) in place, then increment k. After chunk N-1, go to DONE.
  - DONE: out_valid=1 and data_out = buffer. If out_ready and in_valid, load the new state and go to BUSY (back-to-back). If only out_ready, go to IDLE. Otherwise hold.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- data_in is sampled only on the accepting edge. Later changes have no effect.
- data_out stays stable while out_valid && !out_ready.
- Counter width is clog2(N), minimum 1 bit. It never wraps inside a state; it is cleared on every load.
- No error or abort path. The block is a pure byte-wise transform.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE. out_valid=0. data_out=0. Buffer and counter are 0.
- Reset in any state, including mid-BUSY: go to IDLE and discard the partial result. out_valid falls at the next edge.
- Latency: a state accepted at edge t gives out_valid=1 after edge t+N (t+4 for LANES=4).
- Sustained throughput with out_ready tied high: one state per N+1 cycles.
- For LANES=16, N=1: BUSY lasts one cycle.
- Simultaneous in_valid and out_ready in DONE: the output transfer and the new load happen on the same edge, with no bubble.

## Structure
- Shared package aes_pkg holds:
  - AES_STATE_W=128 and AES_BYTE_W=8.
  - The FSM state typedef (IDLE, BUSY, DONE).
- Sub-module inv_sbox: combinational 8-bit in, 8-bit out FIPS-197 inverse S-box lookup, instantiated LANES times. The encrypt path later reuses the same pattern for its forward S-box.
- The top level holds the FSM, the counter, the working buffer, and the chunk mux/demux.

## Test plan
- Reset then all-zero input with LANES=4: data_in=0 → data_out=0x52 in all 16 bytes, out_valid rising exactly 4 cycles after acceptance.
- Known bytes: data_in = 0x637c_ff00 repeated across the 128 bits → each 32-bit word becomes 0x0001_7d52.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → data_out stable, in_ready=0, and a second state presented on in_valid is not consumed. Then raise out_ready together with in_valid → transfer and load on the same edge, and the second result follows 4 cycles later.
- Reset mid-BUSY: assert rst after 2 processing cycles → out_valid stays 0, next cycle is IDLE with in_ready=1, and a fresh state completes correctly.
- Parameter sweep LANES ∈ {1,2,8,16} with 200 random states → out_valid latencies 16, 8, 2, 1, and data_out matches a reference-model inverse S-box.
- Round trip: forward S-box model applied to random plaintext bytes, then fed through the block → output equals the original bytes.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths and the sequencing FSM encoding
// used by the byte-substitution stages.
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = AES_STATE_W / AES_BYTE_W;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_BUSY = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box: one byte in, one byte out.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] in_byte,
    output logic [AES_BYTE_W-1:0] out_byte
);

    // Entry 0 is the most significant byte; each literal is one row (high nibble).
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: accepts a 128-bit state, substitutes LANES
// bytes per cycle in place (MSB chunk first), then offers the result.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4  // legal: 1, 2, 4, 8, 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] data_out
);

    localparam int N       = AES_NUM_BYTES / LANES;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CHUNK_W = LANES * AES_BYTE_W;
    localparam int IDX_W   = $clog2(AES_STATE_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    fsm_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] buf_q, buf_d;

    logic [IDX_W-1:0]       chunk_lsb;
    logic [CHUNK_W-1:0]     chunk_in;
    logic [CHUNK_W-1:0]     chunk_out;

    // Chunk 0 sits at the top of the state, so the LSB offset counts down.
    assign chunk_lsb = IDX_W'((N - 1 - int'(cnt_q)) * CHUNK_W);
    assign chunk_in  = buf_q[chunk_lsb +: CHUNK_W];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .in_byte  (chunk_in[l*AES_BYTE_W +: AES_BYTE_W]),
            .out_byte (chunk_out[l*AES_BYTE_W +: AES_BYTE_W])
        );
    end

    assign out_valid = (state_q == ST_DONE);
    assign data_out  = buf_q;
    assign in_ready  = !rst && ((state_q == ST_IDLE) ||
                                (state_q == ST_DONE && out_ready));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d   = data_in;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                buf_d[chunk_lsb +: CHUNK_W] = chunk_out;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready && in_valid) begin
                    buf_d   = data_in;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule
